// File: rtl/ovi_issue_sched_if.sv
// +----------------------------------------------------------------------+
// | ovi_issue_sched_if : OVI issue/dispatch/completion signal bundle      |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

interface ovi_issue_sched_if #(
  parameter int NUM_CREDITS  = 4,
  parameter int SBID_WIDTH   = 5,
  parameter int MAX_INFLIGHT = 4
);
  localparam int CW = $clog2(NUM_CREDITS + 1);
  localparam int IW = $clog2(MAX_INFLIGHT + 1);

  logic                  CORE_ISSUE_VALID;
  logic                  CORE_KILL;
  logic                  CORE_HALT;
  logic                  VPU_ISSUE_VALID;
  logic [SBID_WIDTH-1:0] VPU_ISSUE_SB_ID;
  logic                  VPU_ISSUE_CREDIT;
  logic                  VPU_DISPATCH_NEXT_SENIOR;
  logic                  VPU_DISPATCH_KILL;
  logic [SBID_WIDTH-1:0] VPU_DISPATCH_SB_ID;
  logic                  VPU_COMPLETED_VALID;
  logic [SBID_WIDTH-1:0] VPU_COMPLETED_SB_ID;
  logic                  CORE_COMPLETED_VALID;
  logic [SBID_WIDTH-1:0] CORE_COMPLETED_SB_ID;
  logic [CW-1:0]         CREDITS;
  logic [IW-1:0]         INFLIGHT;
  logic                  PROTO_ERR;

  // master is the scheduler; slave is the core/VPU environment
  modport master (
    input  CORE_ISSUE_VALID, CORE_KILL, VPU_ISSUE_CREDIT,
           VPU_COMPLETED_VALID, VPU_COMPLETED_SB_ID,
    output CORE_HALT, VPU_ISSUE_VALID, VPU_ISSUE_SB_ID,
           VPU_DISPATCH_NEXT_SENIOR, VPU_DISPATCH_KILL, VPU_DISPATCH_SB_ID,
           CORE_COMPLETED_VALID, CORE_COMPLETED_SB_ID,
           CREDITS, INFLIGHT, PROTO_ERR
  );

  modport slave (
    output CORE_ISSUE_VALID, CORE_KILL, VPU_ISSUE_CREDIT,
           VPU_COMPLETED_VALID, VPU_COMPLETED_SB_ID,
    input  CORE_HALT, VPU_ISSUE_VALID, VPU_ISSUE_SB_ID,
           VPU_DISPATCH_NEXT_SENIOR, VPU_DISPATCH_KILL, VPU_DISPATCH_SB_ID,
           CORE_COMPLETED_VALID, CORE_COMPLETED_SB_ID,
           CREDITS, INFLIGHT, PROTO_ERR
  );
endinterface

`default_nettype wire

// File: rtl/ovi_issue_sched.sv
// +----------------------------------------------------------------------+
// | ovi_issue_sched : credit-based multi-outstanding OVI issue scheduler  |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

module ovi_issue_sched #(
  parameter int NUM_CREDITS  = 4,
  parameter int SBID_WIDTH   = 5,
  parameter int MAX_INFLIGHT = 4
) (
  input  wire logic          CLK,
  input  wire logic          RST_N,
  ovi_issue_sched_if.master  bus
);
  localparam int CW  = $clog2(NUM_CREDITS + 1);
  localparam int IW  = $clog2(MAX_INFLIGHT + 1);
  localparam int NSB = 1 << SBID_WIDTH;

  localparam logic [CW-1:0] c_num_credits  = CW'(NUM_CREDITS);
  localparam logic [IW-1:0] c_max_inflight = IW'(MAX_INFLIGHT);

  logic [CW-1:0]         credits_q, credits_d;
  logic [IW-1:0]         inflight_q, inflight_d;
  logic [SBID_WIDTH-1:0] tail_q, tail_d;
  logic [NSB-1:0]        sb_q, sb_d;
  logic                  disp_vld_q, disp_vld_d;
  logic [SBID_WIDTH-1:0] disp_id_q, disp_id_d;
  logic                  cc_vld_q, cc_vld_d;
  logic [SBID_WIDTH-1:0] cc_id_q, cc_id_d;
  logic                  perr_q, perr_d;

  logic can_issue;
  logic issue;
  logic kill;
  logic comp_ok;
  logic comp_err;

  always_comb begin
    can_issue = (credits_q != '0) && (inflight_q < c_max_inflight) && !sb_q[tail_q];
    issue     = bus.CORE_ISSUE_VALID && can_issue;
    kill      = disp_vld_q && bus.CORE_KILL;
    // A completion racing a kill of the same sb_id is counted once, as a protocol error
    comp_ok   = bus.VPU_COMPLETED_VALID && sb_q[bus.VPU_COMPLETED_SB_ID] &&
                !(kill && (disp_id_q == bus.VPU_COMPLETED_SB_ID));
    comp_err  = bus.VPU_COMPLETED_VALID && !comp_ok;
  end

  always_comb begin
    credits_d  = credits_q;
    inflight_d = inflight_q + IW'(issue) - IW'(kill) - IW'(comp_ok);
    tail_d     = issue ? tail_q + 1'b1 : tail_q;
    sb_d       = sb_q;
    disp_vld_d = issue;
    disp_id_d  = tail_q;
    cc_vld_d   = comp_ok;
    cc_id_d    = bus.VPU_COMPLETED_SB_ID;
    perr_d     = perr_q || comp_err;

    if (issue) sb_d[tail_q] = 1'b1;
    if (kill) sb_d[disp_id_q] = 1'b0;
    if (comp_ok) sb_d[bus.VPU_COMPLETED_SB_ID] = 1'b0;

    if (issue && !bus.VPU_ISSUE_CREDIT) begin
      credits_d = credits_q - 1'b1;
    end else if (!issue && bus.VPU_ISSUE_CREDIT) begin
      if (credits_q == c_num_credits) begin
        perr_d = 1'b1;
      end else begin
        credits_d = credits_q + 1'b1;
      end
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      credits_q  <= c_num_credits;
      inflight_q <= '0;
      tail_q     <= '0;
      sb_q       <= '0;
      disp_vld_q <= 1'b0;
      disp_id_q  <= '0;
      cc_vld_q   <= 1'b0;
      cc_id_q    <= '0;
      perr_q     <= 1'b0;
    end else begin
      credits_q  <= credits_d;
      inflight_q <= inflight_d;
      tail_q     <= tail_d;
      sb_q       <= sb_d;
      disp_vld_q <= disp_vld_d;
      disp_id_q  <= disp_id_d;
      cc_vld_q   <= cc_vld_d;
      cc_id_q    <= cc_id_d;
      perr_q     <= perr_d;
    end
  end

  assign bus.CORE_HALT                = !can_issue;
  assign bus.VPU_ISSUE_VALID          = issue;
  assign bus.VPU_ISSUE_SB_ID          = tail_q;
  assign bus.VPU_DISPATCH_NEXT_SENIOR = disp_vld_q && !bus.CORE_KILL;
  assign bus.VPU_DISPATCH_KILL        = kill;
  assign bus.VPU_DISPATCH_SB_ID       = disp_id_q;
  assign bus.CORE_COMPLETED_VALID     = cc_vld_q;
  assign bus.CORE_COMPLETED_SB_ID     = cc_id_q;
  assign bus.CREDITS                  = credits_q;
  assign bus.INFLIGHT                 = inflight_q;
  assign bus.PROTO_ERR                = perr_q;

endmodule

`default_nettype wire

// File: tb/tb_ovi_issue_sched.sv
// +----------------------------------------------------------------------+
// | tb_ovi_issue_sched : directed self-checking bench for ovi_issue_sched |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

module tb_ovi_issue_sched;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic rst2_n = 1'b0;
  int   tests_run = 0;
  int   tests_failed = 0;

  always #5 clk = ~clk;

  ovi_issue_sched_if #(.NUM_CREDITS(4), .SBID_WIDTH(5), .MAX_INFLIGHT(4)) b ();
  ovi_issue_sched_if #(.NUM_CREDITS(4), .SBID_WIDTH(2), .MAX_INFLIGHT(4)) b2 ();

  ovi_issue_sched #(.NUM_CREDITS(4), .SBID_WIDTH(5), .MAX_INFLIGHT(4)) dut (
    .CLK(clk), .RST_N(rst_n), .bus(b)
  );
  ovi_issue_sched #(.NUM_CREDITS(4), .SBID_WIDTH(2), .MAX_INFLIGHT(4)) dut2 (
    .CLK(clk), .RST_N(rst2_n), .bus(b2)
  );

  task automatic clear_inputs;
    b.CORE_ISSUE_VALID = 0; b.CORE_KILL = 0; b.VPU_ISSUE_CREDIT = 0;
    b.VPU_COMPLETED_VALID = 0; b.VPU_COMPLETED_SB_ID = '0;
    b2.CORE_ISSUE_VALID = 0; b2.CORE_KILL = 0; b2.VPU_ISSUE_CREDIT = 0;
    b2.VPU_COMPLETED_VALID = 0; b2.VPU_COMPLETED_SB_ID = '0;
  endtask

  task automatic do_reset;
    clear_inputs();
    rst_n = 0;
    @(negedge clk);
    rst_n = 1;
  endtask

  task automatic test_reset;
    clear_inputs();
    rst_n = 0;
    @(negedge clk); #1;
    tests_run++; if (b.CREDITS !== 3'd4) begin tests_failed++; $display("FAIL reset_credits: got %0d expected 4", b.CREDITS); end
    tests_run++; if (b.INFLIGHT !== 3'd0) begin tests_failed++; $display("FAIL reset_inflight: got %0d expected 0", b.INFLIGHT); end
    tests_run++; if ({b.VPU_ISSUE_VALID, b.VPU_DISPATCH_NEXT_SENIOR, b.VPU_DISPATCH_KILL, b.CORE_COMPLETED_VALID, b.PROTO_ERR, b.CORE_HALT} !== 6'b0)
      begin tests_failed++; $display("FAIL reset_flags: got %b expected 000000", {b.VPU_ISSUE_VALID, b.VPU_DISPATCH_NEXT_SENIOR, b.VPU_DISPATCH_KILL, b.CORE_COMPLETED_VALID, b.PROTO_ERR, b.CORE_HALT}); end
    rst_n = 1;
  endtask

  task automatic test_fill;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk); b.CORE_ISSUE_VALID = 1; #1;
      tests_run++; if (b.VPU_ISSUE_VALID !== 1'b1 || b.VPU_ISSUE_SB_ID !== 5'(k))
        begin tests_failed++; $display("FAIL fill_issue%0d: got v=%0d id=%0d expected v=1 id=%0d", k, b.VPU_ISSUE_VALID, b.VPU_ISSUE_SB_ID, k); end
      if (k > 0) begin
        tests_run++; if (b.VPU_DISPATCH_NEXT_SENIOR !== 1'b1 || b.VPU_DISPATCH_SB_ID !== 5'(k - 1))
          begin tests_failed++; $display("FAIL fill_disp%0d: got ns=%0d id=%0d expected ns=1 id=%0d", k, b.VPU_DISPATCH_NEXT_SENIOR, b.VPU_DISPATCH_SB_ID, k - 1); end
      end
    end
    @(negedge clk); #1;
    tests_run++; if (b.CORE_HALT !== 1'b1 || b.VPU_ISSUE_VALID !== 1'b0)
      begin tests_failed++; $display("FAIL fill_halt: got halt=%0d v=%0d expected halt=1 v=0", b.CORE_HALT, b.VPU_ISSUE_VALID); end
    tests_run++; if (b.VPU_DISPATCH_NEXT_SENIOR !== 1'b1 || b.VPU_DISPATCH_SB_ID !== 5'd3)
      begin tests_failed++; $display("FAIL fill_disp3: got ns=%0d id=%0d expected ns=1 id=3", b.VPU_DISPATCH_NEXT_SENIOR, b.VPU_DISPATCH_SB_ID); end
    tests_run++; if (b.CREDITS !== 3'd0 || b.INFLIGHT !== 3'd4)
      begin tests_failed++; $display("FAIL fill_counts: got cr=%0d inf=%0d expected cr=0 inf=4", b.CREDITS, b.INFLIGHT); end
  endtask

  task automatic test_complete;
    @(negedge clk); b.CORE_ISSUE_VALID = 0; b.VPU_COMPLETED_VALID = 1; b.VPU_COMPLETED_SB_ID = 5'd2;
    @(negedge clk); b.VPU_COMPLETED_VALID = 0; b.VPU_ISSUE_CREDIT = 1; #1;
    tests_run++; if (b.CORE_COMPLETED_VALID !== 1'b1 || b.CORE_COMPLETED_SB_ID !== 5'd2)
      begin tests_failed++; $display("FAIL comp_fwd: got v=%0d id=%0d expected v=1 id=2", b.CORE_COMPLETED_VALID, b.CORE_COMPLETED_SB_ID); end
    tests_run++; if (b.INFLIGHT !== 3'd3 || b.CORE_HALT !== 1'b1)
      begin tests_failed++; $display("FAIL comp_inflight: got inf=%0d halt=%0d expected inf=3 halt=1", b.INFLIGHT, b.CORE_HALT); end
    @(negedge clk); b.VPU_ISSUE_CREDIT = 0; b.CORE_ISSUE_VALID = 1; #1;
    tests_run++; if (b.CREDITS !== 3'd1 || b.CORE_HALT !== 1'b0 || b.CORE_COMPLETED_VALID !== 1'b0)
      begin tests_failed++; $display("FAIL comp_credit: got cr=%0d halt=%0d cv=%0d expected cr=1 halt=0 cv=0", b.CREDITS, b.CORE_HALT, b.CORE_COMPLETED_VALID); end
    tests_run++; if (b.VPU_ISSUE_VALID !== 1'b1 || b.VPU_ISSUE_SB_ID !== 5'd4)
      begin tests_failed++; $display("FAIL comp_next_id: got v=%0d id=%0d expected v=1 id=4", b.VPU_ISSUE_VALID, b.VPU_ISSUE_SB_ID); end
    @(negedge clk); b.CORE_ISSUE_VALID = 0; #1;
    tests_run++; if (b.VPU_DISPATCH_NEXT_SENIOR !== 1'b1 || b.VPU_DISPATCH_SB_ID !== 5'd4 || b.CREDITS !== 3'd0 || b.INFLIGHT !== 3'd4)
      begin tests_failed++; $display("FAIL comp_after: got ns=%0d id=%0d cr=%0d inf=%0d expected 1 4 0 4", b.VPU_DISPATCH_NEXT_SENIOR, b.VPU_DISPATCH_SB_ID, b.CREDITS, b.INFLIGHT); end
  endtask

  task automatic test_kill;
    do_reset();
    b.CORE_ISSUE_VALID = 1;
    @(negedge clk); b.CORE_ISSUE_VALID = 0; b.CORE_KILL = 1; #1;
    tests_run++; if (b.VPU_DISPATCH_KILL !== 1'b1 || b.VPU_DISPATCH_NEXT_SENIOR !== 1'b0 || b.VPU_DISPATCH_SB_ID !== 5'd0)
      begin tests_failed++; $display("FAIL kill_disp: got k=%0d ns=%0d id=%0d expected 1 0 0", b.VPU_DISPATCH_KILL, b.VPU_DISPATCH_NEXT_SENIOR, b.VPU_DISPATCH_SB_ID); end
    @(negedge clk); #1;
    tests_run++; if (b.VPU_DISPATCH_KILL !== 1'b0)
      begin tests_failed++; $display("FAIL kill_empty: got %0d expected 0", b.VPU_DISPATCH_KILL); end
    tests_run++; if (b.INFLIGHT !== 3'd0 || b.CREDITS !== 3'd3)
      begin tests_failed++; $display("FAIL kill_counts: got inf=%0d cr=%0d expected inf=0 cr=3", b.INFLIGHT, b.CREDITS); end
    b.CORE_KILL = 0; b.VPU_COMPLETED_VALID = 1; b.VPU_COMPLETED_SB_ID = 5'd0;
    @(negedge clk); b.VPU_COMPLETED_VALID = 0; #1;
    tests_run++; if (b.PROTO_ERR !== 1'b1 || b.CORE_COMPLETED_VALID !== 1'b0 || b.INFLIGHT !== 3'd0)
      begin tests_failed++; $display("FAIL kill_stale_comp: got pe=%0d cv=%0d inf=%0d expected 1 0 0", b.PROTO_ERR, b.CORE_COMPLETED_VALID, b.INFLIGHT); end
  endtask

  task automatic test_back_to_back;
    do_reset();
    b.CORE_ISSUE_VALID = 1;
    @(negedge clk);
    @(negedge clk); b.VPU_ISSUE_CREDIT = 1; #1;
    tests_run++; if (b.CREDITS !== 3'd2 || b.INFLIGHT !== 3'd2 || b.VPU_ISSUE_VALID !== 1'b1)
      begin tests_failed++; $display("FAIL b2b_pre: got cr=%0d inf=%0d v=%0d expected 2 2 1", b.CREDITS, b.INFLIGHT, b.VPU_ISSUE_VALID); end
    @(negedge clk); b.CORE_ISSUE_VALID = 0; b.VPU_ISSUE_CREDIT = 0; #1;
    tests_run++; if (b.CREDITS !== 3'd2 || b.INFLIGHT !== 3'd3)
      begin tests_failed++; $display("FAIL b2b_credit: got cr=%0d inf=%0d expected cr=2 inf=3", b.CREDITS, b.INFLIGHT); end
    tests_run++; if (b.VPU_DISPATCH_NEXT_SENIOR !== 1'b1 || b.VPU_DISPATCH_SB_ID !== 5'd2)
      begin tests_failed++; $display("FAIL b2b_disp: got ns=%0d id=%0d expected ns=1 id=2", b.VPU_DISPATCH_NEXT_SENIOR, b.VPU_DISPATCH_SB_ID); end
  endtask

  task automatic test_credit_sat_and_async_reset;
    do_reset();
    b.VPU_ISSUE_CREDIT = 1;
    @(negedge clk); b.VPU_ISSUE_CREDIT = 0; #1;
    tests_run++; if (b.CREDITS !== 3'd4 || b.PROTO_ERR !== 1'b1)
      begin tests_failed++; $display("FAIL credit_sat: got cr=%0d pe=%0d expected cr=4 pe=1", b.CREDITS, b.PROTO_ERR); end
    b.CORE_ISSUE_VALID = 1;
    @(negedge clk); #1;
    #2; rst_n = 0; b.CORE_ISSUE_VALID = 0; #1;
    tests_run++; if (b.CREDITS !== 3'd4 || b.INFLIGHT !== 3'd0)
      begin tests_failed++; $display("FAIL async_counts: got cr=%0d inf=%0d expected cr=4 inf=0", b.CREDITS, b.INFLIGHT); end
    tests_run++; if ({b.VPU_ISSUE_VALID, b.VPU_DISPATCH_NEXT_SENIOR, b.VPU_DISPATCH_KILL, b.CORE_COMPLETED_VALID, b.PROTO_ERR} !== 5'b0)
      begin tests_failed++; $display("FAIL async_flags: got %b expected 00000", {b.VPU_ISSUE_VALID, b.VPU_DISPATCH_NEXT_SENIOR, b.VPU_DISPATCH_KILL, b.CORE_COMPLETED_VALID, b.PROTO_ERR}); end
    @(negedge clk); rst_n = 1; b.VPU_COMPLETED_VALID = 1; b.VPU_COMPLETED_SB_ID = 5'd0;
    @(negedge clk); b.VPU_COMPLETED_VALID = 0; #1;
    tests_run++; if (b.CORE_COMPLETED_VALID !== 1'b0 || b.PROTO_ERR !== 1'b1)
      begin tests_failed++; $display("FAIL async_stale: got cv=%0d pe=%0d expected cv=0 pe=1", b.CORE_COMPLETED_VALID, b.PROTO_ERR); end
  endtask

  task automatic test_wrap;
    rst2_n = 0;
    @(negedge clk); rst2_n = 1; b2.CORE_ISSUE_VALID = 1;
    repeat (4) @(negedge clk);
    b2.CORE_ISSUE_VALID = 0;
    for (int k = 1; k <= 4; k++) begin
      b2.VPU_ISSUE_CREDIT = 1;
      b2.VPU_COMPLETED_VALID = (k < 4);
      b2.VPU_COMPLETED_SB_ID = 2'(k);
      @(negedge clk);
    end
    b2.VPU_ISSUE_CREDIT = 0; b2.VPU_COMPLETED_VALID = 0; b2.CORE_ISSUE_VALID = 1; #1;
    tests_run++; if (b2.CREDITS !== 3'd4 || b2.INFLIGHT !== 3'd1 || b2.VPU_ISSUE_SB_ID !== 2'd0)
      begin tests_failed++; $display("FAIL wrap_state: got cr=%0d inf=%0d tail=%0d expected 4 1 0", b2.CREDITS, b2.INFLIGHT, b2.VPU_ISSUE_SB_ID); end
    tests_run++; if (b2.CORE_HALT !== 1'b1 || b2.VPU_ISSUE_VALID !== 1'b0)
      begin tests_failed++; $display("FAIL wrap_halt: got halt=%0d v=%0d expected halt=1 v=0", b2.CORE_HALT, b2.VPU_ISSUE_VALID); end
    @(negedge clk); b2.VPU_COMPLETED_VALID = 1; b2.VPU_COMPLETED_SB_ID = 2'd0; #1;
    tests_run++; if (b2.CORE_HALT !== 1'b1)
      begin tests_failed++; $display("FAIL wrap_halt_hold: got %0d expected 1", b2.CORE_HALT); end
    @(negedge clk); b2.VPU_COMPLETED_VALID = 0; #1;
    tests_run++; if (b2.CORE_HALT !== 1'b0 || b2.VPU_ISSUE_VALID !== 1'b1 || b2.VPU_ISSUE_SB_ID !== 2'd0)
      begin tests_failed++; $display("FAIL wrap_resume: got halt=%0d v=%0d id=%0d expected 0 1 0", b2.CORE_HALT, b2.VPU_ISSUE_VALID, b2.VPU_ISSUE_SB_ID); end
    tests_run++; if (b2.CORE_COMPLETED_VALID !== 1'b1 || b2.CORE_COMPLETED_SB_ID !== 2'd0)
      begin tests_failed++; $display("FAIL wrap_comp_fwd: got v=%0d id=%0d expected v=1 id=0", b2.CORE_COMPLETED_VALID, b2.CORE_COMPLETED_SB_ID); end
    @(negedge clk); b2.CORE_ISSUE_VALID = 0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    clear_inputs();
    test_reset();
    test_fill();
    test_complete();
    test_kill();
    test_back_to_back();
    test_credit_sat_and_async_reset();
    test_wrap();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule

`default_nettype wire
